// File: rtl/multicycle_control.sv
// Multicycle CPU main controller: sequences fetch/decode/execute/memory/writeback
// and traps on illegal opcodes or memory requests that never complete.
`timescale 1ns/1ps
module multicycle_control #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic       branch_taken,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       mem_addr_sel,
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_sel,
   output logic [1:0] alu_op,
   output logic       alu_src_b,
   output logic       reg_write,
   output logic [1:0] wb_sel,
   output logic       trap,
   output logic [2:0] state_o
);

   // state  | meaning
   // FETCH  | read instruction at PC, wait for mem_ready
   // DECODE | latch opcode, screen for legal encodings
   // EXEC   | ALU operation / branch resolution
   // MEM    | load or store at ALU address, wait for mem_ready
   // WB     | register file write, JAL redirect
   // TRAP   | sticky error, left only by reset
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd7
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);

   state_t           state_q, state_d;
   logic [6:0]       opc_q, opc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout;
   logic             req_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         opc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         opc_q   <= opc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign timeout = (cnt_q == CNT_LIMIT) && !mem_ready;

   always_comb begin
      state_d      = state_q;
      opc_d        = opc_q;
      req_c        = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_sel       = 1'b0;
      alu_op       = 2'b00;
      alu_src_b    = 1'b0;
      reg_write    = 1'b0;
      wb_sel       = 2'b00;
      trap         = 1'b0;

      case (state_q)
         S_FETCH: begin
            req_c    = 1'b1;
            ir_write = mem_ready;
            pc_write = mem_ready;
            if (mem_ready)    state_d = S_DECODE;
            else if (timeout) state_d = S_TRAP;
         end
         S_DECODE: begin
            opc_d = opcode;
            case (opcode)
               OP_R, OP_IMM, OP_LOAD, OP_STORE,
               OP_BRANCH, OP_JAL, OP_LUI: state_d = S_EXEC;
               default:                   state_d = S_TRAP;
            endcase
         end
         S_EXEC: begin
            case (opc_q)
               OP_R: begin
                  alu_op  = 2'b10;
                  state_d = S_WB;
               end
               OP_IMM: begin
                  alu_op    = 2'b11;
                  alu_src_b = 1'b1;
                  state_d   = S_WB;
               end
               OP_BRANCH: begin
                  alu_op   = 2'b01;
                  pc_write = branch_taken;
                  pc_sel   = branch_taken;
                  state_d  = S_FETCH;
               end
               OP_LOAD, OP_STORE: begin
                  alu_src_b = 1'b1;
                  state_d   = S_MEM;
               end
               OP_LUI, OP_JAL: begin
                  alu_src_b = 1'b1;
                  state_d   = S_WB;
               end
               default: state_d = S_TRAP;
            endcase
         end
         S_MEM: begin
            req_c        = 1'b1;
            mem_addr_sel = 1'b1;
            mem_we       = (opc_q == OP_STORE);
            if (mem_ready)    state_d = (opc_q == OP_STORE) ? S_FETCH : S_WB;
            else if (timeout) state_d = S_TRAP;
         end
         S_WB: begin
            reg_write = 1'b1;
            if (opc_q == OP_LOAD) begin
               wb_sel = 2'b01;
            end else if (opc_q == OP_JAL) begin
               wb_sel   = 2'b10;
               pc_write = 1'b1;
               pc_sel   = 1'b1;
            end
            state_d = S_FETCH;
         end
         S_TRAP: trap = 1'b1;
         default: state_d = S_TRAP;
      endcase

      // Count stalled request cycles; any state change or completion restarts it.
      if (req_c && !mem_ready && (state_d == state_q)) cnt_d = cnt_q + CNT_W'(1);
      else                                              cnt_d = '0;

      // Keep the memory side and write enables quiet while reset is held.
      mem_req = req_c & rst_n;
      if (!rst_n) begin
         mem_we       = 1'b0;
         mem_addr_sel = 1'b0;
         ir_write     = 1'b0;
         pc_write     = 1'b0;
         pc_sel       = 1'b0;
         alu_op       = 2'b00;
         alu_src_b    = 1'b0;
         reg_write    = 1'b0;
         wb_sel       = 2'b00;
         trap         = 1'b0;
      end
   end

   assign state_o = state_q;

endmodule
